calc1_port_resp: RTL and testbench

CALC1_PORT_RESP -- requirements
Module: calc1_port_resp

---
 rtl/calc1_port_resp.sv | 86 ++++++++
 tb/tb_calc1_port_resp.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/calc1_port_resp.sv
// calc1_port_resp: two-operand command calculator with a fixed-latency one-cycle response
module calc1_port_resp #(
    parameter int RESP_DELAY = 0
) (
    input  logic        c_clk,
    input  logic        reset,
    input  logic [3:0]  req_cmd_in,
    input  logic [31:0] req_data_in,
    output logic [1:0]  out_resp,
    output logic [31:0] out_data,
    output logic        busy
);
    typedef enum logic [1:0] {IDLE, OP2, WAIT, RESP} state_t;
    state_t      state;
    logic [3:0]  cmd, cnt;
    logic [31:0] op1, op2, b, res;
    logic [32:0] sum;
    logic        err;
    // result of the captured command; in OP2 operand 2 is taken straight from the bus
    always_comb begin
        b   = (state == OP2) ? req_data_in : op2;
        sum = {1'b0, op1} + {1'b0, b};
        err = 1'b0;
        res = '0;
        case (cmd)
            4'd1: begin
                err = sum[32];
                res = sum[32] ? '0 : sum[31:0];
            end
            4'd2: begin
                err = b > op1;
                res = (b > op1) ? '0 : op1 - b;
            end
            4'd5: res = op1 << b[4:0];
            4'd6: res = op1 >> b[4:0];
            default: err = 1'b1;
        endcase
    end
    // control FSM; the response registers are loaded on entry to RESP and cleared on every other edge
    always_ff @(posedge c_clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            cmd      <= '0;
            op1      <= '0;
            op2      <= '0;
            cnt      <= '0;
            busy     <= 1'b0;
            out_resp <= 2'd0;
            out_data <= '0;
        end else begin
            out_resp <= 2'd0;
            out_data <= '0;
            case (state)
                IDLE: if (req_cmd_in != 4'd0) begin
                    cmd   <= req_cmd_in;
                    op1   <= req_data_in;
                    busy  <= 1'b1;
                    state <= OP2;
                end
                OP2: begin
                    op2 <= req_data_in;
                    cnt <= 4'(RESP_DELAY);
                    if (RESP_DELAY > 0) begin
                        state <= WAIT;
                    end else begin
                        state    <= RESP;
                        out_resp <= err ? 2'd2 : 2'd1;
                        out_data <= res;
                    end
                end
                WAIT: begin
                    cnt <= cnt - 4'd1;
                    if (cnt == 4'd1) begin
                        state    <= RESP;
                        out_resp <= err ? 2'd2 : 2'd1;
                        out_data <= res;
                    end
                end
                RESP: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_calc1_port_resp.sv
// tb_calc1_port_resp: directed vector bench for calc1_port_resp at RESP_DELAY 0 and 3
module tb_calc1_port_resp;
    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  cmd;
    logic [31:0] data;
    logic [1:0]  resp0, resp3;
    logic [31:0] dat0, dat3;
    logic        busy0, busy3;
    int          checks = 0;
    int          failures = 0;

    typedef struct {
        logic [3:0]  cmd;
        logic [31:0] a;
        logic [31:0] b;
        logic [1:0]  resp;
        logic [31:0] data;
    } vec_t;

    calc1_port_resp #(.RESP_DELAY(0)) u0 (
        .c_clk(clk), .reset(reset), .req_cmd_in(cmd), .req_data_in(data),
        .out_resp(resp0), .out_data(dat0), .busy(busy0)
    );
    calc1_port_resp #(.RESP_DELAY(3)) u3 (
        .c_clk(clk), .reset(reset), .req_cmd_in(cmd), .req_data_in(data),
        .out_resp(resp3), .out_data(dat3), .busy(busy3)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // starts at a falling edge: command now, operand 2 next cycle, response the cycle after
    task automatic run(input vec_t v);
        cmd  = v.cmd;
        data = v.a;
        @(negedge clk);
        chk("op2_busy", 32'(busy0), 32'd1);
        chk("op2_resp", 32'(resp0), 32'd0);
        cmd  = 4'd0;
        data = v.b;
        @(negedge clk);
        chk("resp", 32'(resp0), 32'(v.resp));
        chk("data", dat0, v.data);
        data = '0;
        @(negedge clk);
        chk("post_resp", 32'(resp0), 32'd0);
        chk("post_data", dat0, 32'd0);
        chk("post_busy", 32'(busy0), 32'd0);
    endtask

    vec_t vecs[13];
    int   nbusy;

    initial begin
        vecs[0]  = '{4'd1, 32'h0000_0001, 32'h1FFF_FFFF, 2'd1, 32'h2000_0000};
        vecs[1]  = '{4'd1, 32'hFFFF_FFFF, 32'h0000_0001, 2'd2, 32'h0};
        vecs[2]  = '{4'd1, 32'hFFFF_FFFE, 32'h0000_0001, 2'd1, 32'hFFFF_FFFF};
        vecs[3]  = '{4'd2, 32'h0000_0001, 32'h0000_000F, 2'd2, 32'h0};
        vecs[4]  = '{4'd2, 32'h0000_0005, 32'h0000_0005, 2'd1, 32'h0};
        vecs[5]  = '{4'd2, 32'h0000_000A, 32'h0000_0003, 2'd1, 32'h7};
        vecs[6]  = '{4'd5, 32'h0000_0001, 32'h0000_0023, 2'd1, 32'h8};
        vecs[7]  = '{4'd6, 32'h8000_0000, 32'h0000_001F, 2'd1, 32'h1};
        vecs[8]  = '{4'd5, 32'h0000_00F0, 32'h0000_0000, 2'd1, 32'hF0};
        vecs[9]  = '{4'd6, 32'h0000_00F0, 32'hFFFF_FFE4, 2'd1, 32'hF};
        vecs[10] = '{4'd3, 32'h1234_5678, 32'h1, 2'd2, 32'h0};
        vecs[11] = '{4'd4, 32'h1234_5678, 32'h1, 2'd2, 32'h0};
        vecs[12] = '{4'd15, 32'h0000_0001, 32'h1, 2'd2, 32'h0};

        reset = 1'b1;
        cmd   = 4'd0;
        data  = '0;
        repeat (2) @(negedge clk);
        chk("rst_resp", 32'(resp0), 32'd0);
        chk("rst_data", dat0, 32'd0);
        chk("rst_busy", 32'(busy0), 32'd0);
        chk("rst_busy3", 32'(busy3), 32'd0);
        reset = 1'b0;
        for (int i = 0; i < 13; i++) run(vecs[i]);

        // a new command while busy is ignored and produces no extra response
        cmd  = 4'd1;
        data = 32'd2;
        @(negedge clk);
        data = 32'd3;
        @(negedge clk);
        chk("busy_resp", 32'(resp0), 32'd1);
        chk("busy_data", dat0, 32'd5);
        cmd  = 4'd1;
        data = 32'd100;
        @(negedge clk);
        cmd  = 4'd0;
        data = '0;
        for (int i = 0; i < 4; i++) begin
            chk("no_extra_resp", 32'(resp0), 32'd0);
            chk("no_extra_busy", 32'(busy0), 32'd0);
            @(negedge clk);
        end

        // delayed response: 2 + 3 on the RESP_DELAY = 3 instance
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        cmd   = 4'd1;
        data  = 32'd2;
        nbusy = 0;
        for (int i = 1; i <= 6; i++) begin
            @(negedge clk);
            if (i == 1) begin
                cmd  = 4'd0;
                data = 32'd3;
            end else begin
                data = '0;
            end
            nbusy += int'(busy3);
            chk("d3_resp", 32'(resp3), (i == 5) ? 32'd1 : 32'd0);
            chk("d3_data", dat3, (i == 5) ? 32'd5 : 32'd0);
        end
        chk("d3_busy_cycles", 32'(nbusy), 32'd5);

        // reset in OP2 discards the pending command
        repeat (2) @(negedge clk);
        cmd  = 4'd1;
        data = 32'd7;
        @(negedge clk);
        cmd  = 4'd0;
        data = 32'd8;
        chk("pre_rst_busy", 32'(busy0), 32'd1);
        reset = 1'b1;
        #1;
        chk("arst_busy", 32'(busy0), 32'd0);
        chk("arst_busy3", 32'(busy3), 32'd0);
        chk("arst_resp", 32'(resp0), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        data  = '0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("no_resp0", 32'(resp0), 32'd0);
            chk("no_resp3", 32'(resp3), 32'd0);
        end
        run('{4'd1, 32'h0, 32'h0, 2'd1, 32'h0});

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
